qft4_row_sequencer: RTL and testbench

QFT4_ROW_SEQUENCER -- requirements
Module: qft4_row_sequencer

---
 rtl/qft4_row_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_qft4_row_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qft4_row_sequencer.sv
// qft4_row_sequencer: row-by-row sequencer for a 4-point quantum Fourier transform.
// It latches one complex state vector and presents it to an external dot-product stage.
// Over four cycles it steps the row twiddles and captures each row result.
// It then holds the transformed vector until the consumer takes it.
module qft4_row_sequencer #(
    parameter int NORM = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [7:0]  in_r0,
    input  logic signed [7:0]  in_r1,
    input  logic signed [7:0]  in_r2,
    input  logic signed [7:0]  in_r3,
    input  logic signed [7:0]  in_i0,
    input  logic signed [7:0]  in_i1,
    input  logic signed [7:0]  in_i2,
    input  logic signed [7:0]  in_i3,
    output logic signed [7:0]  vec_r0,
    output logic signed [7:0]  vec_r1,
    output logic signed [7:0]  vec_r2,
    output logic signed [7:0]  vec_r3,
    output logic signed [7:0]  vec_i0,
    output logic signed [7:0]  vec_i1,
    output logic signed [7:0]  vec_i2,
    output logic signed [7:0]  vec_i3,
    output logic signed [11:0] cos_2p_by_0,
    output logic signed [11:0] cos_2p_by_1,
    output logic signed [11:0] cos_2p_by_2,
    output logic signed [11:0] cos_2p_by_3,
    output logic signed [11:0] sin_2p_by_0,
    output logic signed [11:0] sin_2p_by_1,
    output logic signed [11:0] sin_2p_by_2,
    output logic signed [11:0] sin_2p_by_3,
    input  logic signed [12:0] dp_out_r,
    input  logic signed [12:0] dp_out_i,
    output logic signed [12:0] res_r0,
    output logic signed [12:0] res_r1,
    output logic signed [12:0] res_r2,
    output logic signed [12:0] res_r3,
    output logic signed [12:0] res_i0,
    output logic signed [12:0] res_i1,
    output logic signed [12:0] res_i2,
    output logic signed [12:0] res_i3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             r_state;
    logic [1:0]         r_k;
    logic signed [7:0]  r_vecR [4];
    logic signed [7:0]  r_vecI [4];
    logic signed [12:0] r_resR [4];
    logic signed [12:0] r_resI [4];

    logic signed [12:0] w_capR;
    logic signed [12:0] w_capI;
    logic [1:0]         w_phase [4];
    logic signed [11:0] w_cos [4];
    logic signed [11:0] w_sin [4];

    // The 1/sqrt(4) normalisation is a floor halving; arithmetic shift keeps the sign.
    assign w_capR = (NORM != 0) ? (dp_out_r >>> 1) : dp_out_r;
    assign w_capI = (NORM != 0) ? (dp_out_i >>> 1) : dp_out_i;

    // Control FSM: accept a vector, capture one row per RUN cycle, then hold until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_k     <= 2'd0;
            for (int j = 0; j < 4; j++) begin
                r_vecR[j] <= '0;
                r_vecI[j] <= '0;
                r_resR[j] <= '0;
                r_resI[j] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_vecR[0] <= in_r0;
                        r_vecR[1] <= in_r1;
                        r_vecR[2] <= in_r2;
                        r_vecR[3] <= in_r3;
                        r_vecI[0] <= in_i0;
                        r_vecI[1] <= in_i1;
                        r_vecI[2] <= in_i2;
                        r_vecI[3] <= in_i3;
                        r_k       <= 2'd0;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_resR[r_k] <= w_capR;
                    r_resI[r_k] <= w_capI;
                    r_k         <= r_k + 2'd1;
                    if (r_k == 2'd3) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Row twiddles: column j of row k uses the quarter-turn index (j*k) mod 4; row 0 outside RUN.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_phase[j] = 2'd0;
            w_cos[j]   = 12'sd1024;
            w_sin[j]   = 12'sd0;
            if (r_state == ST_RUN) begin
                w_phase[j] = 2'(j * int'(r_k));
            end
            case (w_phase[j])
                2'd0: begin
                    w_cos[j] = 12'sd1024;
                    w_sin[j] = 12'sd0;
                end
                2'd1: begin
                    w_cos[j] = 12'sd0;
                    w_sin[j] = 12'sd1024;
                end
                2'd2: begin
                    w_cos[j] = -12'sd1024;
                    w_sin[j] = 12'sd0;
                end
                default: begin
                    w_cos[j] = 12'sd0;
                    w_sin[j] = -12'sd1024;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);

    assign vec_r0 = r_vecR[0];
    assign vec_r1 = r_vecR[1];
    assign vec_r2 = r_vecR[2];
    assign vec_r3 = r_vecR[3];
    assign vec_i0 = r_vecI[0];
    assign vec_i1 = r_vecI[1];
    assign vec_i2 = r_vecI[2];
    assign vec_i3 = r_vecI[3];

    assign cos_2p_by_0 = w_cos[0];
    assign cos_2p_by_1 = w_cos[1];
    assign cos_2p_by_2 = w_cos[2];
    assign cos_2p_by_3 = w_cos[3];
    assign sin_2p_by_0 = w_sin[0];
    assign sin_2p_by_1 = w_sin[1];
    assign sin_2p_by_2 = w_sin[2];
    assign sin_2p_by_3 = w_sin[3];

    assign res_r0 = r_resR[0];
    assign res_r1 = r_resR[1];
    assign res_r2 = r_resR[2];
    assign res_r3 = r_resR[3];
    assign res_i0 = r_resI[0];
    assign res_i1 = r_resI[1];
    assign res_i2 = r_resI[2];
    assign res_i3 = r_resI[3];

endmodule

// File: tb/tb_qft4_row_sequencer.sv
// Testbench for qft4_row_sequencer: two instances (NORM=0 and NORM=1) share stimulus.
// Each instance has its own zero-delay dot-product model.
// Results are compared to a direct 4-point DFT computed from the input vector.
module tb_qft4_row_sequencer;

    logic              clk;
    logic              rst_n;
    logic              inValid;
    logic              outReady;
    logic signed [7:0] inR [4];
    logic signed [7:0] inI [4];

    // Index d: 0 = NORM=0 instance, 1 = NORM=1 instance
    logic               inReady  [2];
    logic               outValid [2];
    logic               busy     [2];
    logic signed [7:0]  vR [2][4];
    logic signed [7:0]  vI [2][4];
    logic signed [11:0] cs [2][4];
    logic signed [11:0] sn [2][4];
    logic signed [12:0] dpR [2];
    logic signed [12:0] dpI [2];
    logic signed [12:0] rR [2][4];
    logic signed [12:0] rI [2][4];

    int checks;
    int failures;
    int curR [4];
    int curI [4];
    int expR [2][4];
    int expI [2][4];
    int cosTab [4] = '{1024, 0, -1024, 0};
    int sinTab [4] = '{0, 1024, 0, -1024};

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dot-product stage: bus value is 8 times the exact complex sum of vec * twiddle/1024
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            int sr;
            int si;
            sr = 0;
            si = 0;
            for (int j = 0; j < 4; j++) begin
                sr += int'(vR[d][j]) * int'(cs[d][j]) - int'(vI[d][j]) * int'(sn[d][j]);
                si += int'(vR[d][j]) * int'(sn[d][j]) + int'(vI[d][j]) * int'(cs[d][j]);
            end
            dpR[d] = 13'((sr * 8) / 1024);
            dpI[d] = 13'((si * 8) / 1024);
        end
    end

    qft4_row_sequencer #(.NORM(0)) dutN0 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady[0]),
        .in_r0(inR[0]), .in_r1(inR[1]), .in_r2(inR[2]), .in_r3(inR[3]),
        .in_i0(inI[0]), .in_i1(inI[1]), .in_i2(inI[2]), .in_i3(inI[3]),
        .vec_r0(vR[0][0]), .vec_r1(vR[0][1]), .vec_r2(vR[0][2]), .vec_r3(vR[0][3]),
        .vec_i0(vI[0][0]), .vec_i1(vI[0][1]), .vec_i2(vI[0][2]), .vec_i3(vI[0][3]),
        .cos_2p_by_0(cs[0][0]), .cos_2p_by_1(cs[0][1]), .cos_2p_by_2(cs[0][2]), .cos_2p_by_3(cs[0][3]),
        .sin_2p_by_0(sn[0][0]), .sin_2p_by_1(sn[0][1]), .sin_2p_by_2(sn[0][2]), .sin_2p_by_3(sn[0][3]),
        .dp_out_r(dpR[0]), .dp_out_i(dpI[0]),
        .res_r0(rR[0][0]), .res_r1(rR[0][1]), .res_r2(rR[0][2]), .res_r3(rR[0][3]),
        .res_i0(rI[0][0]), .res_i1(rI[0][1]), .res_i2(rI[0][2]), .res_i3(rI[0][3]),
        .out_valid(outValid[0]), .out_ready(outReady), .busy(busy[0])
    );

    qft4_row_sequencer #(.NORM(1)) dutN1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady[1]),
        .in_r0(inR[0]), .in_r1(inR[1]), .in_r2(inR[2]), .in_r3(inR[3]),
        .in_i0(inI[0]), .in_i1(inI[1]), .in_i2(inI[2]), .in_i3(inI[3]),
        .vec_r0(vR[1][0]), .vec_r1(vR[1][1]), .vec_r2(vR[1][2]), .vec_r3(vR[1][3]),
        .vec_i0(vI[1][0]), .vec_i1(vI[1][1]), .vec_i2(vI[1][2]), .vec_i3(vI[1][3]),
        .cos_2p_by_0(cs[1][0]), .cos_2p_by_1(cs[1][1]), .cos_2p_by_2(cs[1][2]), .cos_2p_by_3(cs[1][3]),
        .sin_2p_by_0(sn[1][0]), .sin_2p_by_1(sn[1][1]), .sin_2p_by_2(sn[1][2]), .sin_2p_by_3(sn[1][3]),
        .dp_out_r(dpR[1]), .dp_out_i(dpI[1]),
        .res_r0(rR[1][0]), .res_r1(rR[1][1]), .res_r2(rR[1][2]), .res_r3(rR[1][3]),
        .res_i0(rI[1][0]), .res_i1(rI[1][1]), .res_i2(rI[1][2]), .res_i3(rI[1][3]),
        .out_valid(outValid[1]), .out_ready(outReady), .busy(busy[1])
    );

    // Single comparison point: counts every check and reports any difference
    task automatic checkOutput(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // Halving with rounding toward minus infinity
    function automatic int floorHalf(input int v);
        if (v >= 0) return v / 2;
        return -((-v + 1) / 2);
    endfunction

    // Direct DFT: X[k] = 8 * sum_j x[j] * i^(j*k), optionally halved
    task automatic computeExpected();
        for (int k = 0; k < 4; k++) begin
            int sr;
            int si;
            sr = 0;
            si = 0;
            for (int j = 0; j < 4; j++) begin
                case ((j * k) % 4)
                    0: begin sr += curR[j]; si += curI[j]; end
                    1: begin sr -= curI[j]; si += curR[j]; end
                    2: begin sr -= curR[j]; si -= curI[j]; end
                    default: begin sr += curI[j]; si -= curR[j]; end
                endcase
            end
            expR[0][k] = 8 * sr;
            expI[0][k] = 8 * si;
            expR[1][k] = floorHalf(8 * sr);
            expI[1][k] = floorHalf(8 * si);
        end
    endtask

    task automatic clearExpected();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                expR[d][k] = 0;
                expI[d][k] = 0;
            end
        end
    endtask

    task automatic setVector(input int r0, input int r1, input int r2, input int r3,
                             input int i0, input int i1, input int i2, input int i3);
        curR = '{r0, r1, r2, r3};
        curI = '{i0, i1, i2, i3};
        computeExpected();
    endtask

    task automatic setRandomVector();
        for (int j = 0; j < 4; j++) begin
            curR[j] = int'($urandom_range(254)) - 127;
            curI[j] = int'($urandom_range(254)) - 127;
        end
        computeExpected();
    endtask

    // Present the current vector with in_valid high
    task automatic applyStimulus();
        for (int j = 0; j < 4; j++) begin
            inR[j] = 8'(curR[j]);
            inI[j] = 8'(curI[j]);
        end
        inValid = 1'b1;
    endtask

    task automatic checkTwiddles(input string tag, input int row);
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < 4; j++) begin
                checkOutput($sformatf("%s d%0d cos%0d", tag, d, j), 32'(cs[d][j]), cosTab[(j * row) % 4]);
                checkOutput($sformatf("%s d%0d sin%0d", tag, d, j), 32'(sn[d][j]), sinTab[(j * row) % 4]);
            end
        end
    endtask

    task automatic checkVec(input string tag);
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < 4; j++) begin
                checkOutput($sformatf("%s d%0d vec_r%0d", tag, d, j), 32'(vR[d][j]), curR[j]);
                checkOutput($sformatf("%s d%0d vec_i%0d", tag, d, j), 32'(vI[d][j]), curI[j]);
            end
        end
    endtask

    task automatic checkResults(input string tag);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("%s d%0d res_r%0d", tag, d, k), 32'(rR[d][k]), expR[d][k]);
                checkOutput($sformatf("%s d%0d res_i%0d", tag, d, k), 32'(rI[d][k]), expI[d][k]);
            end
        end
    endtask

    task automatic checkFlags(input string tag, input logic expRdy, input logic expVal, input logic expBusy);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s d%0d in_ready", tag, d), 32'(inReady[d]), 32'(expRdy));
            checkOutput($sformatf("%s d%0d out_valid", tag, d), 32'(outValid[d]), 32'(expVal));
            checkOutput($sformatf("%s d%0d busy", tag, d), 32'(busy[d]), 32'(expBusy));
        end
    endtask

    // Drive the current vector through the accept edge and confirm it was latched
    task automatic acceptVector(input string tag);
        applyStimulus();
        checkFlags({tag, " pre-accept"}, 1'b1, 1'b0, 1'b0);
        stepClk();
        inValid = 1'b0;
        checkVec({tag, " accept"});
    endtask

    // From just after the accept edge: four RUN cycles, then out_valid on the 4th edge
    task automatic runRows(input string tag);
        for (int c = 0; c < 4; c++) begin
            checkFlags($sformatf("%s run%0d", tag, c), 1'b0, 1'b0, 1'b1);
            checkTwiddles($sformatf("%s run%0d", tag, c), c);
            stepClk();
        end
        checkFlags({tag, " done"}, 1'b0, 1'b1, 1'b1);
        checkTwiddles({tag, " done"}, 0);
        checkResults({tag, " done"});
    endtask

    // Single-cycle out_ready pulse; results must survive the return to IDLE
    task automatic handshake(input string tag);
        outReady = 1'b1;
        stepClk();
        outReady = 1'b0;
        checkFlags({tag, " idle"}, 1'b1, 1'b0, 1'b0);
        checkResults({tag, " held"});
    endtask

    task automatic fullTransform(input string tag);
        acceptVector(tag);
        runRows(tag);
        handshake(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        for (int j = 0; j < 4; j++) begin
            inR[j] = '0;
            inI[j] = '0;
        end

        // Reset state
        repeat (3) stepClk();
        clearExpected();
        curR = '{0, 0, 0, 0};
        curI = '{0, 0, 0, 0};
        checkFlags("reset low", 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        stepClk();
        checkFlags("reset", 1'b1, 1'b0, 1'b0);
        checkResults("reset");
        checkVec("reset");
        checkTwiddles("reset", 0);

        // Directed vectors
        setVector(64, 0, 0, 0, 0, 0, 0, 0);
        fullTransform("basis0");
        setVector(0, 32, 0, 0, 0, 0, 0, 0);
        fullTransform("basis1");
        setVector(16, 16, 16, 16, 0, 0, 0, 0);
        fullTransform("uniform");
        setVector(-1, 0, 0, 0, 0, 0, 0, 0);
        fullTransform("minus1");
        setVector(-3, 0, 0, 0, 0, 0, 0, 0);
        fullTransform("minus3");
        setVector(127, 127, 127, 127, -127, -127, -127, -127);
        fullTransform("extreme");

        // Randomized vectors
        for (int n = 0; n < 8; n++) begin
            setRandomVector();
            fullTransform($sformatf("rand%0d", n));
        end

        // Backpressure: consumer stalls while a new vector is offered
        setRandomVector();
        acceptVector("bp");
        runRows("bp");
        for (int c = 0; c < 10; c++) begin
            for (int j = 0; j < 4; j++) begin
                inR[j] = 8'($urandom_range(255));
                inI[j] = 8'($urandom_range(255));
            end
            inValid = 1'b1;
            stepClk();
            checkFlags($sformatf("bp stall%0d", c), 1'b0, 1'b1, 1'b1);
            checkVec($sformatf("bp stall%0d", c));
            checkResults($sformatf("bp stall%0d", c));
        end
        handshake("bp");
        setRandomVector();
        applyStimulus();
        stepClk();
        inValid = 1'b0;
        checkVec("bp next accept");
        runRows("bp next");
        handshake("bp next");

        // Reset while row 2 is being computed
        setRandomVector();
        acceptVector("midrst");
        stepClk();
        stepClk();
        checkTwiddles("midrst k2", 2);
        rst_n = 1'b0;
        #1;
        clearExpected();
        curR = '{0, 0, 0, 0};
        curI = '{0, 0, 0, 0};
        checkFlags("midrst", 1'b1, 1'b0, 1'b0);
        checkResults("midrst");
        checkVec("midrst");
        checkTwiddles("midrst", 0);
        stepClk();
        rst_n = 1'b1;
        stepClk();
        checkFlags("midrst released", 1'b1, 1'b0, 1'b0);
        setRandomVector();
        fullTransform("after rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
